sonar_scan_scheduler: RTL and testbench
=======================================

# sonar_scan_scheduler

Round-robin scan controller that shares the single ranging time base among `NUM_SENSORS` HC-SR04 ultrasonic sensors. On each sample tick it fires every sensor once, strictly one at a time, so echoes never overlap. For each sensor it generates the trigger pulse, times the echo in microseconds, converts the width to centimetres and presents one result per sensor on a valid/ready interface. It runs in the 125 MHz domain and is paced by single-cycle tick enables derived from the robot clock system.

## Interface
Parameters:
- `NUM_SENSORS`, 3: number of sensors scanned (2..4).
- `TRIG_US`, 10: trigger pulse width in µs.
- `TIMEOUT_US`, 30000: maximum wait for echo rise, and maximum echo width, in µs.
- `US_PER_CM`, 58: echo µs per cm.
- `DIST_W`, 9: width of the distance result.
- `GAP_US`, 2000: guard gap between sensors; used only with `SONAR_SCHED_GAP_EN`.

Ports:
- `clk_125mhz`, in, 1: system clock. One clock; reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high.
- `tick_1us`, in, 1: one-cycle enable, 1 MHz rate.
- `tick_sample`, in, 1: one-cycle enable, 20 Hz rate; starts a scan round.
- `echo`, in, `NUM_SENSORS`: raw echo lines (asynchronous).
- `trig`, out, `NUM_SENSORS`: trigger lines.
- `dist_cm`, out, `DIST_W`: distance result.
- `dist_id`, out, `$clog2(NUM_SENSORS)`: sensor index of the result.
- `dist_timeout`, out, 1: result is a timeout.
- `dist_valid`, out, 1: result valid.
- `dist_ready`, in, 1: consumer accepts the result.
- `busy`, out, 1: scan round in progress.

## Operation
- Each `echo` bit passes through a 2-flop synchronizer. All decisions use the synchronized level and its rising/falling edges.
- State machine:
  - **IDLE**: `busy`=0. On `tick_sample`, set sensor index to 0 and go to TRIG.
  - **TRIG**: `trig[idx]`=1. Count `tick_1us`. After the `TRIG_US`-th tick, drop `trig` and go to WAIT_RISE with the µs counter cleared.
  - **WAIT_RISE**: count `tick_1us`.
    - On echo rise: clear the counters and go to MEASURE.
    - When the count reaches `TIMEOUT_US`: go to PRESENT with timeout.
  - **MEASURE**: each `tick_1us` while echo is high advances a prescaler 0..`US_PER_CM`-1. On prescaler wrap, `cm`+1, saturating at 2^`DIST_W`-1.
    - On echo fall: go to PRESENT.
    - When total µs reaches `TIMEOUT_US`: go to PRESENT with timeout.
  - **PRESENT**: drive `dist_valid`=1 together with `dist_id`=idx.
    - Normal result: `dist_cm`=floor(n/`US_PER_CM`), where n is the number of `tick_1us` seen while echo was high, saturated. `dist_timeout`=0.
    - Timeout result: `dist_cm`=all ones, `dist_timeout`=1.
    - Hold all result outputs stable until the cycle `dist_valid && dist_ready`.
    - On acceptance: if idx=`NUM_SENSORS`-1, go to IDLE; otherwise idx+1 and go to GAP (macro on) or TRIG (macro off).
  - **GAP**: wait `GAP_US` ticks, then go to TRIG.
- `tick_sample` is ignored in every state except IDLE. Ignored ticks are not queued.
- An echo that is already high on entry to WAIT_RISE is not a rise. The block waits for a low→high transition.
- Echo activity on non-selected sensors is ignored.

## Timing
- Reset values: `trig`=0, `dist_cm`=0, `dist_id`=0, `dist_timeout`=0, `dist_valid`=0, `busy`=0, state IDLE, idx=0.
- Reset asserted mid-operation drops `trig` and `dist_valid` immediately (asynchronously). Any partial result is discarded.
- `tick_sample` at cycle t: `busy`=1 and `trig[0]`=1 at t+1.
- `trig` falls on the cycle after the `TRIG_US`-th `tick_1us`.
- Raw echo edge to detected edge: 2 cycles of synchronizer delay plus 1 cycle of edge detect.
- Detected echo fall to `dist_valid`=1: 1 cycle.
- Acceptance to next sensor's `trig`=1 (macro off): 1 cycle.
- Acceptance of the last result: `busy`=0 the next cycle.
- `dist_valid` and `tick_1us` in the same cycle: timing counters are frozen in PRESENT.
- `dist_ready` high with `dist_valid` low: no effect.

## Configuration
- `SONAR_SCHED_GAP_EN` defined:
  - GAP state is compiled in.
  - `GAP_US` µs of silence separate consecutive sensors within a round, to suppress residual echoes.
- Not defined:
  - GAP state and its counter are absent.
  - The next sensor triggers 1 cycle after acceptance.
  - `GAP_US` is unused.

## Test plan
- **Nominal echo**: `tick_sample`, sensor 0 echo high for 580 `tick_1us` → `dist_valid`=1, `dist_id`=0, `dist_cm`=10, `dist_timeout`=0. Also check that `trig[0]` was high for exactly 10 ticks.
- **No echo**: sensor 1 never rises → after 30000 ticks, `dist_id`=1, `dist_cm`=511, `dist_timeout`=1.
- **Full round**: echo widths 116, 1160 and 5800 µs on sensors 0, 1, 2 with `dist_ready`=1 → results 2, 20, 100 cm with ids 0, 1, 2 in order. No two `trig` bits are ever high together. `busy`=0 after the third acceptance.
- **Backpressure**: `dist_ready`=0 for 500 cycles → outputs stable throughout, no `trig` activity. Accept → next sensor triggers.
- **Reset mid-trigger**: assert `reset` while `trig[0]`=1 → `trig`=0 in the same cycle. After release, the block is IDLE and the next `tick_sample` restarts from sensor 0.
- **Busy ticks**: `tick_sample` pulses during MEASURE → ignored, exactly `NUM_SENSORS` results per round. With `SONAR_SCHED_GAP_EN`, the next sensor's `trig` starts `GAP_US` ticks after acceptance.

Source files
------------

// File: rtl/sonar_scan_scheduler_if.sv
// Result channel of the sonar scan scheduler: one distance word per sensor per round.
// Latency: n/a (interface only).
// Backpressure: master holds every field stable while dist_valid is high and dist_ready is low.
interface sonar_scan_scheduler_if #(
  parameter int NUM_SENSORS = 3,
  parameter int DIST_W      = 9
);
  localparam int ID_W = $clog2(NUM_SENSORS);

  logic [DIST_W-1:0] dist_cm;
  logic [ID_W-1:0]   dist_id;
  logic              dist_timeout;
  logic              dist_valid;
  logic              dist_ready;

  modport master (
    output dist_cm, dist_id, dist_timeout, dist_valid,
    input  dist_ready
  );

  modport slave (
    input  dist_cm, dist_id, dist_timeout, dist_valid,
    output dist_ready
  );
endinterface

// File: rtl/sonar_scan_scheduler.sv
// Round-robin HC-SR04 scan controller: triggers each sensor in turn and reports echo width in cm.
// Latency: tick_sample -> trig[0] 1 cycle; detected echo fall -> dist_valid 1 cycle.
// Backpressure: result held stable until dist_ready; scan stalls while a result is pending.
// Optional feature macro: SONAR_SCHED_GAP_EN inserts a GAP_US guard gap between sensors.
module sonar_scan_scheduler #(
  parameter int NUM_SENSORS = 3,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int US_PER_CM   = 58,
  parameter int DIST_W      = 9,
  parameter int GAP_US      = 2000
) (
  input  logic                   clk_125mhz,
  input  logic                   reset,
  input  logic                   tick_1us,
  input  logic                   tick_sample,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  sonar_scan_scheduler_if.master res
);

  localparam int ID_W   = $clog2(NUM_SENSORS);
  // One shared microsecond counter times every interval, so it is sized for the longest one.
  localparam int MAX_A  = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int MAX_US = (MAX_A > GAP_US) ? MAX_A : GAP_US;
  localparam int CNT_W  = $clog2(MAX_US + 1);
  localparam int PRE_W  = $clog2(US_PER_CM + 1);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = {DIST_W{1'b1}};
  localparam logic [ID_W-1:0]   IDX_LAST  = ID_W'(NUM_SENSORS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] PRESENT   = 3'd4;
`ifdef SONAR_SCHED_GAP_EN
  localparam logic [2:0] GAP       = 3'd5;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_US - 1);
`endif

  logic [2:0]             state;
  logic [ID_W-1:0]        idx;
  logic [CNT_W-1:0]       us_cnt;
  logic [PRE_W-1:0]       pre_cnt;
  logic [DIST_W-1:0]      cm;
  logic [DIST_W-1:0]      dist_cm_q;
  logic [ID_W-1:0]        dist_id_q;
  logic                   dist_timeout_q;
  logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_s3;

  logic echo_lvl, echo_rise, echo_fall;

  // Two-flop synchronizer per echo line, plus one more stage for edge detection.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // Only the selected sensor's echo is looked at.
  assign echo_lvl  = echo_s2[idx];
  assign echo_rise = echo_s2[idx] & ~echo_s3[idx];
  assign echo_fall = ~echo_s2[idx] & echo_s3[idx];

  // Scan sequencer: trigger, wait for rise, measure, present, next sensor.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      us_cnt         <= '0;
      pre_cnt        <= '0;
      cm             <= '0;
      dist_cm_q      <= '0;
      dist_id_q      <= '0;
      dist_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_sample) begin
            idx    <= '0;
            us_cnt <= '0;
            state  <= TRIG;
          end
        end
        TRIG: begin
          if (tick_1us) begin
            if (us_cnt == TRIG_LAST) begin
              us_cnt <= '0;
              state  <= WAIT_RISE;
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            // The synchronized echo is already high in this cycle, so a tick here counts.
            us_cnt  <= {{(CNT_W-1){1'b0}}, tick_1us};
            pre_cnt <= {{(PRE_W-1){1'b0}}, tick_1us & (PRE_LAST != '0)};
            cm      <= {{(DIST_W-1){1'b0}}, tick_1us & (PRE_LAST == '0)};
            state   <= MEASURE;
          end else if (tick_1us) begin
            if (us_cnt == TMO_LAST) begin
              dist_cm_q      <= CM_MAX;
              dist_timeout_q <= 1'b1;
              dist_id_q      <= idx;
              state          <= PRESENT;
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            dist_cm_q      <= cm;
            dist_timeout_q <= 1'b0;
            dist_id_q      <= idx;
            state          <= PRESENT;
          end else if (tick_1us) begin
            if (us_cnt == TMO_LAST) begin
              dist_cm_q      <= CM_MAX;
              dist_timeout_q <= 1'b1;
              dist_id_q      <= idx;
              state          <= PRESENT;
            end else begin
              us_cnt <= us_cnt + 1'b1;
              if (echo_lvl) begin
                if (pre_cnt == PRE_LAST) begin
                  pre_cnt <= '0;
                  if (cm != CM_MAX) cm <= cm + 1'b1;
                end else begin
                  pre_cnt <= pre_cnt + 1'b1;
                end
              end
            end
          end
        end
        PRESENT: begin
          // Counters stay frozen until the consumer takes the result.
          if (res.dist_ready) begin
            if (idx == IDX_LAST) begin
              state <= IDLE;
            end else begin
              idx    <= idx + 1'b1;
              us_cnt <= '0;
`ifdef SONAR_SCHED_GAP_EN
              state  <= GAP;
`else
              state  <= TRIG;
`endif
            end
          end
        end
`ifdef SONAR_SCHED_GAP_EN
        GAP: begin
          if (tick_1us) begin
            if (us_cnt == GAP_LAST) begin
              us_cnt <= '0;
              state  <= TRIG;
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Trigger decoded straight from the state register so reset drops it immediately.
  always_comb begin
    trig = '0;
    if (state == TRIG) trig[idx] = 1'b1;
  end

  assign busy             = (state != IDLE);
  assign res.dist_valid   = (state == PRESENT);
  assign res.dist_cm      = dist_cm_q;
  assign res.dist_id      = dist_id_q;
  assign res.dist_timeout = dist_timeout_q;

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Scoreboard bench for sonar_scan_scheduler: per-round expected results are queued at stimulus time.
// Echo models answer each trigger with a programmed width counted in tick_1us periods.
// Backpressure, reset mid-trigger and ignored sample ticks are exercised in sequence.
module tb_sonar_scan_scheduler;
  localparam int N  = 3;
  localparam int DW = 9;

  logic         clk_125mhz = 1'b0;
  logic         reset = 1'b1;
  logic         tick_1us = 1'b0;
  logic         tick_sample = 1'b0;
  logic         ready = 1'b1;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic         busy;

  sonar_scan_scheduler_if #(.NUM_SENSORS(N), .DIST_W(DW)) res ();
  assign res.dist_ready = ready;

  sonar_scan_scheduler #(.NUM_SENSORS(N), .DIST_W(DW)) dut (
    .clk_125mhz  (clk_125mhz),
    .reset       (reset),
    .tick_1us    (tick_1us),
    .tick_sample (tick_sample),
    .echo        (echo),
    .trig        (trig),
    .busy        (busy),
    .res         (res)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Tick generator: one tick every 3 cycles, or every cycle in fast mode (no-echo timeout only).
  logic fast = 1'b0;
  int   ph = 0;
  initial begin
    forever begin
      @(posedge clk_125mhz); #1;
      if (fast) tick_1us = 1'b1;
      else begin
        tick_1us = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end
    end
  end

  // Echo models: after trig falls, go high right after a tick and stay high for echo_w ticks.
  int echo_w [N];
  for (genvar g = 0; g < N; g++) begin : g_echo
    logic raw = 1'b0;
    assign echo[g] = raw;
    initial begin
      int cnt;
      forever begin
        @(negedge trig[g]);
        if (echo_w[g] >= 0) begin
          do begin @(posedge clk_125mhz); #2; end while (!tick_1us);
          @(posedge clk_125mhz); #2; raw = 1'b1;
          cnt = 0;
          while (cnt < echo_w[g]) begin
            @(posedge clk_125mhz); #2;
            if (tick_1us) cnt++;
          end
          @(posedge clk_125mhz); #2; raw = 1'b0;
        end
      end
    end
  end

  // Trigger watcher: ticks per trigger pulse and overlap detection.
  int           tcnt [N];
  int           trig_ticks [N];
  logic [N-1:0] trig_prev = '0;
  logic         overlap = 1'b0;
  always @(negedge clk_125mhz) begin
    for (int i = 0; i < N; i++) begin
      if (trig[i] && !trig_prev[i]) tcnt[i] = tick_1us ? 1 : 0;
      else if (trig[i] && tick_1us) tcnt[i] = tcnt[i] + 1;
      if (!trig[i] && trig_prev[i]) trig_ticks[i] = tcnt[i];
    end
    if ($countones(trig) > 1) overlap = 1'b1;
    trig_prev = trig;
  end

  // Scoreboard.
  typedef struct { int id; int cm; int to; } exp_t;
  exp_t sb [$];
  exp_t e;
  int   n_results = 0;
  logic busy_chk = 1'b0;

  task automatic push_round(input int w0, input int w1, input int w2);
    int w [N];
    exp_t x;
    w = '{w0, w1, w2};
    for (int i = 0; i < N; i++) begin
      echo_w[i] = w[i];
      x.id = i;
      x.to = (w[i] < 0) ? 1 : 0;
      x.cm = (w[i] < 0) ? 511 : ((w[i] / 58 > 511) ? 511 : w[i] / 58);
      sb.push_back(x);
    end
  endtask

  always @(negedge clk_125mhz) begin
    if (busy_chk) begin
      chk("busy_after_last", busy, 0);
      busy_chk = 1'b0;
    end
    if (res.dist_valid && ready && !reset) begin
      chk("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dist_id", res.dist_id, e.id);
        chk("dist_cm", res.dist_cm, e.cm);
        chk("dist_timeout", res.dist_timeout, e.to);
        if (e.id == N - 1) busy_chk = 1'b1;
      end
      n_results++;
    end
  end

  task automatic start_round();
    @(posedge clk_125mhz); #1; tick_sample = 1'b1;
    @(posedge clk_125mhz); #1; tick_sample = 1'b0;
    @(negedge clk_125mhz);
    chk("busy_start", busy, 1);
    chk("trig0_start", trig, 1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int c = 0;
    while (busy && c < lim) begin @(negedge clk_125mhz); c++; end
    chk(tag, busy, 0);
    repeat (3) @(negedge clk_125mhz);
  endtask

  initial begin
    #760000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    logic stable, quiet;
    logic [DW-1:0] cap_cm;
    logic [1:0]    cap_id;
    logic          cap_to;

    echo_w = '{-1, -1, -1};

    // Reset state.
    repeat (3) @(posedge clk_125mhz);
    @(negedge clk_125mhz);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res.dist_valid, 0);
    chk("rst_cm", res.dist_cm, 0);
    chk("rst_id", res.dist_id, 0);
    chk("rst_timeout", res.dist_timeout, 0);
    @(posedge clk_125mhz); #1; reset = 1'b0;

    // Nominal echo on sensor 0, no echo on sensor 1.
    push_round(580, -1, 116);
    start_round();
    c = 0;
    while (!trig[1] && c < 20000) begin @(negedge clk_125mhz); c++; end
    chk("trig1_seen", trig[1], 1);
    fast = 1'b1;
    c = 0;
    while (n_results < 2 && c < 40000) begin @(negedge clk_125mhz); c++; end
    chk("timeout_result_seen", n_results >= 2, 1);
    fast = 1'b0;
    wait_idle("idle_a", 20000);
    chk("trig0_ticks", trig_ticks[0], 10);
    chk("trig1_ticks", trig_ticks[1], 10);

    // Full round with increasing widths.
    push_round(116, 1160, 5800);
    start_round();
    wait_idle("idle_b", 30000);

    // Backpressure on the first result.
    push_round(58, 58, 58);
    ready = 1'b0;
    start_round();
    c = 0;
    while (!res.dist_valid && c < 5000) begin @(negedge clk_125mhz); c++; end
    chk("bp_valid", res.dist_valid, 1);
    cap_cm = res.dist_cm;
    cap_id = res.dist_id;
    cap_to = res.dist_timeout;
    stable = 1'b1;
    quiet  = 1'b1;
    repeat (500) begin
      @(negedge clk_125mhz);
      if (!res.dist_valid || res.dist_cm != cap_cm || res.dist_id != cap_id ||
          res.dist_timeout != cap_to) stable = 1'b0;
      if (trig != '0) quiet = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_trig_quiet", quiet, 1);
    @(posedge clk_125mhz); #1; ready = 1'b1;
    @(negedge clk_125mhz);
    @(negedge clk_125mhz);
`ifdef SONAR_SCHED_GAP_EN
    chk("bp_next_trig", trig, 0);
`else
    chk("bp_next_trig", trig, 3'b010);
`endif
    wait_idle("idle_c", 20000);

    // Reset while sensor 0 is being triggered.
    echo_w = '{-1, -1, -1};
    start_round();
    @(negedge clk_125mhz); #1;
    reset = 1'b1;
    #1;
    chk("midrst_trig", trig, 0);
    chk("midrst_valid", res.dist_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk_125mhz); #1; reset = 1'b0;
    repeat (5) @(negedge clk_125mhz);
    chk("post_rst_idle", busy, 0);

    // Sample ticks during MEASURE are ignored.
    push_round(580, 116, 58);
    base = n_results;
    start_round();
    c = 0;
    while (!echo[0] && c < 5000) begin @(negedge clk_125mhz); c++; end
    chk("echo0_seen", echo[0], 1);
    repeat (20) @(negedge clk_125mhz);
    repeat (3) begin
      @(posedge clk_125mhz); #1; tick_sample = 1'b1;
      @(posedge clk_125mhz); #1; tick_sample = 1'b0;
      repeat (10) @(posedge clk_125mhz);
    end
    wait_idle("idle_e", 20000);
    repeat (50) @(negedge clk_125mhz);
    chk("round_result_count", n_results - base, N);
    chk("stay_idle", busy, 0);

    chk("no_trig_overlap", overlap, 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
